// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer and the control unit that stalls on it.
package div_sequencer_pkg;

    localparam int unsigned TIMEOUT_DEF = 40;
    localparam int unsigned DATA_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_sequencer_timer.sv
// Wait-cycle counter for the divide sequencer; expired flags the last permitted WAIT cycle.
module div_timer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned       CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/div_sequencer.sv
// Sequences one DIV through an external divider and owns the architectural HI/LO registers.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_req,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              abort,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hilo_wdata,
    output logic              div_start,
    output logic              div_abort,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              div_done,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              hilo_valid,
    output logic              div0_exc,
    output logic              tmo_exc
);

    div_state_e        state_q;
    logic              zero_q;
    logic              busy_q;
    logic              start_q;
    logic              abort_q;
    logic              valid_q;
    logic              div0_q;
    logic              tmo_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              timer_clr_s;
    logic              timer_en_s;
    logic              expired_s;

    assign timer_clr_s = (state_q == S_LAUNCH);
    assign timer_en_s  = (state_q == S_WAIT);

    div_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (timer_clr_s),
        .en_i      (timer_en_s),
        .expired_o (expired_s)
    );

    // Control FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            div0_q  <= 1'b0;
            tmo_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            div0_q  <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // MTHI/MTLO land now; a division started this cycle may overwrite them later.
                    if (hi_we) hi_q <= hilo_wdata;
                    if (lo_we) lo_q <= hilo_wdata;
                    if (div_req) begin
                        a_q    <= rs_val;
                        b_q    <= rt_val;
                        busy_q <= 1'b1;
                        if (rt_val != {DATA_W{1'b0}}) begin
                            state_q <= S_LAUNCH;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            zero_q  <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Abort outranks a coincident done so a flushed result never reaches HI/LO.
                    if (abort) begin
                        state_q <= S_IDLE;
                        abort_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (div_done) begin
                        hi_q    <= div_hi;
                        lo_q    <= div_lo;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (expired_s) begin
                        state_q <= S_ERR;
                        zero_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_ERR: begin
                    div0_q  <= zero_q;
                    tmo_q   <= ~zero_q;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_start  = start_q;
    assign div_abort  = abort_q;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign busy       = busy_q;
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign hilo_valid = valid_q;
    assign div0_exc   = div0_q;
    assign tmo_exc    = tmo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench: expected pulses are queued at issue time, a negedge monitor pops and compares.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int TMO   = 40;
    localparam int NEVER = 9999;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_req = 1'b0, abort = 1'b0, hi_we = 1'b0, lo_we = 1'b0, div_done = 1'b0;
    logic [31:0] rs_val = 32'd0, rt_val = 32'd0, hilo_wdata = 32'd0;
    logic [31:0] div_hi = 32'd0, div_lo = 32'd0;
    logic        div_start, div_abort, busy, hilo_valid, div0_exc, tmo_exc;
    logic [31:0] div_a, div_b, HI, LO;

    div_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .div_req(div_req), .rs_val(rs_val), .rt_val(rt_val),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
        .div_start(div_start), .div_abort(div_abort), .div_a(div_a), .div_b(div_b),
        .div_hi(div_hi), .div_lo(div_lo), .div_done(div_done), .busy(busy),
        .HI(HI), .LO(LO), .hilo_valid(hilo_valid), .div0_exc(div0_exc), .tmo_exc(tmo_exc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_START, EV_ABORT, EV_VALID, EV_DIV0, EV_TMO} ev_e;
    typedef struct {
        ev_e         kind;
        int          cyc;
        logic [31:0] x;
        logic [31:0] y;
    } ev_t;

    ev_t         sbq[$];
    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_e k);
        ev_t e;
        if (sbq.size() == 0) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_%s: pulse at cycle %0d, expected none", k.name(), cyc);
        end else begin
            e = sbq.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_cycle", cyc, e.cyc);
            if (k == EV_START) begin
                check("div_a", div_a, e.x);
                check("div_b", div_b, e.y);
            end else begin
                check("HI_at_event", HI, e.x);
                check("LO_at_event", LO, e.y);
            end
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (div_start)  expect_ev(EV_START);
            if (div_abort)  expect_ev(EV_ABORT);
            if (hilo_valid) expect_ev(EV_VALID);
            if (div0_exc)   expect_ev(EV_DIV0);
            if (tmo_exc)    expect_ev(EV_TMO);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_HI"}, HI, 32'd0);
        check({tag, "_LO"}, LO, 32'd0);
        check({tag, "_div_a"}, div_a, 32'd0);
        check({tag, "_div_b"}, div_b, 32'd0);
        check({tag, "_pulses"}, {27'd0, div_start, div_abort, hilo_valid, div0_exc, tmo_exc}, 32'd0);
    endtask

    // One DIV request; offsets (k) count cycles from the request cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int done_k,
                           input int abort_k, input logic wh, input logic wl,
                           input int mt_k, input int rst_k);
        int          t0;
        int          idle_k;
        logic        done_ok;
        logic [31:0] q, r, wd, mtd;
        t0  = cyc;
        wd  = $urandom;
        mtd = $urandom;
        q   = (b != 32'd0) ? a / b : 32'd0;
        r   = (b != 32'd0) ? a % b : 32'd0;
        if (wh) hi_m = wd;
        if (wl) lo_m = wd;
        done_ok = (done_k >= 2) && (done_k <= TMO + 1);
        if (b == 32'd0) begin
            sbq.push_back('{kind: EV_DIV0, cyc: t0 + 2, x: hi_m, y: lo_m});
            idle_k = 2;
        end else begin
            sbq.push_back('{kind: EV_START, cyc: t0 + 1, x: a, y: b});
            if (abort_k >= 1 && abort_k <= TMO + 1 && (!done_ok || abort_k <= done_k)) begin
                sbq.push_back('{kind: EV_ABORT, cyc: t0 + abort_k + 1, x: hi_m, y: lo_m});
                idle_k = abort_k + 1;
            end else if (done_ok) begin
                hi_m = r;
                lo_m = q;
                sbq.push_back('{kind: EV_VALID, cyc: t0 + done_k + 1, x: hi_m, y: lo_m});
                idle_k = done_k + 2;
            end else begin
                sbq.push_back('{kind: EV_TMO, cyc: t0 + TMO + 3, x: hi_m, y: lo_m});
                idle_k = TMO + 3;
            end
        end
        for (int k = 0; k < idle_k; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            div_req    = (k == 0);
            rs_val     = (k == 0) ? a : $urandom;
            rt_val     = (k == 0) ? b : $urandom;
            hi_we      = (k == 0) ? wh : 1'b0;
            lo_we      = (k == 0) ? wl : (k == mt_k);
            hilo_wdata = (k == 0) ? wd : mtd;
            abort      = (k == abort_k);
            div_done   = (k == done_k);
            div_hi     = (k == done_k) ? r : $urandom;
            div_lo     = (k == done_k) ? q : $urandom;
            if (k == 1) check("busy_active", 32'(busy), 32'd1);
            if (k == rst_k) begin
                #2 reset = 1'b0;
                #1 check_all_zero("reset_mid_op");
                sbq.delete();
                hi_m = 32'd0;
                lo_m = 32'd0;
                {div_req, abort, hi_we, lo_we, div_done} = 5'd0;
                @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
        end
        @(posedge clk);
        #1;
        {div_req, abort, hi_we, lo_we, div_done} = 5'd0;
        check("busy_idle", 32'(busy), 32'd0);
        check("HI_after", HI, hi_m);
        check("LO_after", LO, lo_m);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            hi_we      = 1'($urandom_range(0, 1));
            lo_we      = 1'($urandom_range(0, 1));
            hilo_wdata = $urandom;
            if (hi_we) hi_m = hilo_wdata;
            if (lo_we) lo_m = hilo_wdata;
            @(posedge clk);
            #1;
            hi_we = 1'b0;
            lo_we = 1'b0;
            check("HI_idle_write", HI, hi_m);
            check("LO_idle_write", LO, lo_m);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int          dk, ak;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        run_div(32'd100, 32'd7, 33, NEVER, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd5, 32'd0, NEVER, 1, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd1234, 32'd10, NEVER, NEVER, 1'b0, 1'b0, 20, NEVER);
        run_div(32'd1000, 32'd9, 20, 12, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd77, 32'd8, 15, 15, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd77, 32'd8, 15, 16, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd500, 32'd3, TMO + 1, NEVER, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd500, 32'd4, TMO + 2, NEVER, 1'b0, 1'b0, NEVER, NEVER);
        run_div(32'd42, 32'd5, NEVER, 1, 1'b1, 1'b1, NEVER, NEVER);
        run_div(32'd43, 32'd6, 4, 0, 1'b1, 1'b1, NEVER, NEVER);

        hi_we      = 1'b1;
        hilo_wdata = 32'hDEADBEEF;
        hi_m       = 32'hDEADBEEF;
        @(posedge clk);
        #1 hi_we = 1'b0;
        check("mthi_deadbeef", HI, 32'hDEADBEEF);
        run_div(32'd50, 32'd5, NEVER, 5, 1'b0, 1'b0, 3, NEVER);

        run_div(32'd20, 32'd4, NEVER, NEVER, 1'b0, 1'b0, NEVER, 10);
        run_div(32'd9, 32'd3, 6, NEVER, 1'b0, 1'b0, NEVER, NEVER);
        check("post_reset_LO", LO, 32'd3);
        check("post_reset_HI", HI, 32'd0);

        for (int i = 0; i < 30; i++) begin
            idle_cycles($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            dk = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(2, TMO + 4);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 2) : NEVER;
            if (b == 32'd0) dk = NEVER;
            run_div(a, b, dk, ak, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 6), NEVER);
        end

        repeat (3) @(posedge clk);
        nchk++;
        if (sbq.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
